top: RTL and testbench

Top level of the simple accumulator processor used for threshold classification. It contains a fixed 16-word program ROM, a 16×8 data RAM, an 8-bit accumulator, flags and a PC. After reset it runs a built-in program that classifies an input sample against two thresholds, writes the class (0/1/2) to data address 15 and halts. The data-memory read port is the only output and shows the result once halted.

---
 rtl/top.sv | 155 +++++++++++++++
 tb/tb_top.sv | 125 ++++++++++++
 2 files changed

// File: rtl/top.sv
`default_nettype none
// ============================================================================
// Module   : top
// Purpose  : Single-cycle 8-bit accumulator processor with a fixed 16-word
//            program ROM and a 16x8 data RAM. The built-in program
//            classifies the sample in M[0] against the thresholds in M[1]
//            and M[2], writes the class (0/1/2) to M[15] and halts.
// Revision : 1.0  initial release
// ============================================================================
module top #(
    parameter logic [7:0] INPUT_VALUE = 8'd25,
    parameter logic [7:0] THR_LO      = 8'd10,
    parameter logic [7:0] THR_HI      = 8'd20
) (
    input  logic       clk,
    input  logic       reset,          // asynchronous, active-low
    output logic [7:0] mem_read_data
);

    localparam logic [3:0] C_OP_NOP = 4'h0;
    localparam logic [3:0] C_OP_LDA = 4'h1;
    localparam logic [3:0] C_OP_STA = 4'h2;
    localparam logic [3:0] C_OP_ADD = 4'h3;
    localparam logic [3:0] C_OP_SUB = 4'h4;
    localparam logic [3:0] C_OP_LDI = 4'h5;
    localparam logic [3:0] C_OP_JMP = 4'h6;
    localparam logic [3:0] C_OP_JC  = 4'h7;
    localparam logic [3:0] C_OP_JZ  = 4'h8;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    // Architectural state
    logic [3:0] pc_q, pc_d;
    logic [7:0] a_q,  a_d;
    logic       c_q,  c_d;
    logic       z_q,  z_d;
    logic [7:0] mem_q [16];

    // Decode / datapath wires
    logic [7:0] w_instr;
    logic [3:0] w_opcode;
    logic [3:0] w_operand;
    logic [7:0] w_mem_rd;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic       w_we;

    // Program ROM: fetch the instruction addressed by the current PC
    always_comb begin
        w_instr = 8'h00;
        case (pc_q)
            4'h0: w_instr = 8'h10;  // LDA 0
            4'h1: w_instr = 8'h41;  // SUB 1
            4'h2: w_instr = 8'h78;  // JC  8
            4'h3: w_instr = 8'h10;  // LDA 0
            4'h4: w_instr = 8'h42;  // SUB 2
            4'h5: w_instr = 8'h7A;  // JC  A
            4'h6: w_instr = 8'h52;  // LDI 2
            4'h7: w_instr = 8'h6B;  // JMP B
            4'h8: w_instr = 8'h50;  // LDI 0
            4'h9: w_instr = 8'h6B;  // JMP B
            4'hA: w_instr = 8'h51;  // LDI 1
            4'hB: w_instr = 8'h2F;  // STA F
            4'hC: w_instr = 8'hFF;  // HLT F (keeps the read port on M[15])
            default: w_instr = 8'h00;
        endcase
    end

    assign w_opcode      = w_instr[7:4];
    assign w_operand     = w_instr[3:0];
    assign w_mem_rd      = mem_q[w_operand];
    assign mem_read_data = w_mem_rd;

    // The 9th bit of the subtraction is the borrow, i.e. A < M[a] unsigned
    assign w_sum  = {1'b0, a_q} + {1'b0, w_mem_rd};
    assign w_diff = {1'b0, a_q} - {1'b0, w_mem_rd};

    // Execute: next-state for PC, accumulator, flags and the RAM write strobe
    always_comb begin
        pc_d = pc_q + 4'd1;
        a_d  = a_q;
        c_d  = c_q;
        z_d  = z_q;
        w_we = 1'b0;
        case (w_opcode)
            C_OP_LDA: begin
                a_d = w_mem_rd;
                z_d = (w_mem_rd == 8'd0);
            end
            C_OP_STA: begin
                w_we = 1'b1;
            end
            C_OP_ADD: begin
                a_d = w_sum[7:0];
                c_d = w_sum[8];
                z_d = (w_sum[7:0] == 8'd0);
            end
            C_OP_SUB: begin
                a_d = w_diff[7:0];
                c_d = w_diff[8];
                z_d = (w_diff[7:0] == 8'd0);
            end
            C_OP_LDI: begin
                a_d = {4'b0000, w_operand};
                z_d = (w_operand == 4'd0);
            end
            C_OP_JMP: begin
                pc_d = w_operand;
            end
            C_OP_JC: begin
                if (c_q) pc_d = w_operand;
            end
            C_OP_JZ: begin
                if (z_q) pc_d = w_operand;
            end
            C_OP_HLT: begin
                pc_d = pc_q;
            end
            C_OP_NOP: begin
            end
            default: begin
            end
        endcase
    end

    // Register file update: PC, accumulator and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= 4'd0;
            a_q  <= 8'd0;
            c_q  <= 1'b0;
            z_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            a_q  <= a_d;
            c_q  <= c_d;
            z_q  <= z_d;
        end
    end

    // Data RAM: reset reloads the sample and thresholds, clears the rest
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'd0;
            end
            mem_q[0] <= INPUT_VALUE;
            mem_q[1] <= THR_LO;
            mem_q[2] <= THR_HI;
        end else if (w_we) begin
            mem_q[w_operand] <= a_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_top
// Purpose  : Directed bench for the threshold-classification processor.
//            Five instances cover class 2 (default), class 0, class 1 and
//            both threshold-equality boundaries, sharing clock and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_top;

    logic       clk;
    logic       reset;
    logic [7:0] rd_c2, rd_c0, rd_c1, rd_lo, rd_hi;

    int vectors;
    int miscompares;

    top u_c2 (.clk(clk), .reset(reset), .mem_read_data(rd_c2));
    top #(.INPUT_VALUE(8'd5))  u_c0 (.clk(clk), .reset(reset), .mem_read_data(rd_c0));
    top #(.INPUT_VALUE(8'd15)) u_c1 (.clk(clk), .reset(reset), .mem_read_data(rd_c1));
    top #(.INPUT_VALUE(8'd10)) u_lo (.clk(clk), .reset(reset), .mem_read_data(rd_lo));
    top #(.INPUT_VALUE(8'd20)) u_hi (.clk(clk), .reset(reset), .mem_read_data(rd_hi));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving the bench at the following falling edge
    task automatic run_edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;

        // Reset state: read port shows M[0] of each instance
        #12;
        check("rst_rd_c2", rd_c2, 8'h19);
        check("rst_rd_c0", rd_c0, 8'h05);
        check("rst_rd_c1", rd_c1, 8'h0F);
        check("rst_rd_lo", rd_lo, 8'h0A);
        check("rst_rd_hi", rd_hi, 8'h14);
        check("rst_pc_c2", {4'h0, u_c2.pc_q}, 8'h00);
        check("rst_a_c2",  u_c2.a_q, 8'h00);

        // Release reset between edges
        @(negedge clk);
        reset = 1'b1;

        // Class 0 path: STA pending after 5 edges, halted after 6
        run_edges(5);
        check("c0_pc_e5", {4'h0, u_c0.pc_q}, 8'h0B);
        run_edges(1);
        check("c0_rd_e6", rd_c0, 8'h00);
        check("c0_pc_e6", {4'h0, u_c0.pc_q}, 8'h0C);
        check("c0_a_e6",  u_c0.a_q, 8'h00);
        check("c0_z_e6",  {7'h0, u_c0.z_q}, 8'h01);

        // Class 1 path: halted after 8 edges
        run_edges(1);
        check("c1_pc_e7", {4'h0, u_c1.pc_q}, 8'h0B);
        check("c1_rd_e7", rd_c1, 8'h00);
        run_edges(1);
        check("c1_rd_e8", rd_c1, 8'h01);
        check("c1_pc_e8", {4'h0, u_c1.pc_q}, 8'h0C);
        check("lo_rd_e8", rd_lo, 8'h01);
        check("c2_pc_e8", {4'h0, u_c2.pc_q}, 8'h0B);
        check("c2_rd_e8", rd_c2, 8'h00);

        // Class 2 path: halted after 9 edges
        run_edges(1);
        check("c2_rd_e9", rd_c2, 8'h02);
        check("c2_pc_e9", {4'h0, u_c2.pc_q}, 8'h0C);
        check("hi_rd_e9", rd_hi, 8'h02);

        // Results hold while halted
        run_edges(11);
        check("c2_rd_e20", rd_c2, 8'h02);
        check("c0_rd_e20", rd_c0, 8'h00);
        check("c1_rd_e20", rd_c1, 8'h01);
        check("lo_rd_e20", rd_lo, 8'h01);
        check("hi_rd_e20", rd_hi, 8'h02);
        check("c2_pc_e20", {4'h0, u_c2.pc_q}, 8'h0C);

        // Asynchronous reset after halt, away from any clock edge
        #2;
        reset = 1'b0;
        #1;
        check("arst_rd_c2",  rd_c2, 8'h19);
        check("arst_m15_c2", u_c2.mem_q[15], 8'h00);
        check("arst_pc_c2",  {4'h0, u_c2.pc_q}, 8'h00);
        check("arst_rd_c0",  rd_c0, 8'h05);

        // Held reset with clock running: no progress
        run_edges(3);
        check("hold_rd_c2", rd_c2, 8'h19);
        check("hold_pc_c2", {4'h0, u_c2.pc_q}, 8'h00);

        // Rerun from PC=0 and re-halt with class 2
        reset = 1'b1;
        run_edges(8);
        check("rerun_rd_e8", rd_c2, 8'h00);
        run_edges(1);
        check("rerun_rd_e9", rd_c2, 8'h02);
        check("rerun_pc_e9", {4'h0, u_c2.pc_q}, 8'h0C);
        check("rerun_c1",    rd_c1, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
